// File: rtl/ftdnn_act_pkg.sv
// Shared types and constants for the activation feeder.
// ACTBUF_DATA_LEN falls back to 8 when the conv configuration header is not in scope.
`ifndef ACTBUF_DATA_LEN
`define ACTBUF_DATA_LEN 8
`endif

package ftdnn_act_pkg;

  localparam int ACT_DATA_W  = `ACTBUF_DATA_LEN;
  localparam int STALL_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } act_feeder_state_t;

  typedef logic [2*ACT_DATA_W-1:0] act_word_t;

endpackage

// File: rtl/ftdnn_act_feeder_if.sv
// Control, element-stream and actbuf-write signals of the activation feeder.
// slave = feeder side, master = the side driving configuration and elements.
interface ftdnn_act_feeder_if
  import ftdnn_act_pkg::*;
#(
  parameter int DATA_W = ACT_DATA_W,
  parameter int CNT_W  = 16
);

  logic [CNT_W-1:0]       cfg_len;
  logic                   cfg_start;
  logic                   busy;
  logic                   done;
  logic [DATA_W-1:0]      s_data;
  logic                   s_vld;
  logic                   s_rdy;
  logic [2*DATA_W-1:0]    actbuf_wr_data;
  logic                   actbuf_wr_vld;
  logic                   actbuf_wr_req;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport slave (
    input  cfg_len, cfg_start, s_data, s_vld, actbuf_wr_req,
    output busy, done, s_rdy, actbuf_wr_data, actbuf_wr_vld, stall_cnt
  );

  modport master (
    output cfg_len, cfg_start, s_data, s_vld, actbuf_wr_req,
    input  busy, done, s_rdy, actbuf_wr_data, actbuf_wr_vld, stall_cnt
  );

endinterface

// File: rtl/ftdnn_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
// DEPTH must be a power of two >= 2; head reads as zero while empty.
module ftdnn_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_l,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      level_reg, level_next;
  logic             full_reg, empty_reg;
  logic             do_push, do_pop;

  assign do_push    = push && !full_reg;
  assign do_pop     = pop && !empty_reg;
  assign level_next = level_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);

  always_ff @(posedge clk_l) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
      full_reg  <= (level_next == (AW+1)'(DEPTH));
      empty_reg <= (level_next == '0);
    end
  end

  assign head  = empty_reg ? '0 : mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;
  assign level = level_reg;

endmodule

// File: rtl/ftdnn_act_feeder.sv
// Packs element pairs into actbuf words per layer and buffers them in a FWFT FIFO.
// Optional backpressure counter: define FTDNN_ACT_FEEDER_STALL_CNT_EN.
module ftdnn_act_feeder
  import ftdnn_act_pkg::*;
#(
  parameter int DATA_W     = ACT_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input logic                clk_l,
  input logic                rst_n,
  ftdnn_act_feeder_if.slave  bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  act_feeder_state_t   state_reg, state_next;
  logic [CNT_W-1:0]    remaining_reg, remaining_next;
  logic                half_reg, half_next;
  logic [DATA_W-1:0]   low_reg, low_next;
  logic                rdy, accept, push, pop;
  logic [2*DATA_W-1:0] push_data;
  logic                fifo_full, fifo_empty;
  logic [LVL_W-1:0]    fifo_level;

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      half_reg      <= 1'b0;
      low_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      half_reg      <= half_next;
      low_reg       <= low_next;
    end
  end

  assign pop = !fifo_empty && bus.actbuf_wr_req;

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    half_next      = half_reg;
    low_next       = low_reg;
    rdy            = 1'b0;
    accept         = 1'b0;
    push           = 1'b0;
    push_data      = '0;
    case (state_reg)
      IDLE: begin
        if (bus.cfg_start) begin
          if (bus.cfg_len != '0) begin
            remaining_next = bus.cfg_len;
            half_next      = 1'b0;
            state_next     = RUN;
          end else begin
            state_next = DONE;
          end
        end
      end
      RUN: begin
        // Ready depends only on registered state, never on actbuf_wr_req.
        rdy    = (remaining_reg != '0) && !fifo_full;
        accept = rdy && bus.s_vld;
        if (accept) begin
          remaining_next = remaining_reg - CNT_W'(1);
          half_next      = !half_reg;
          if (half_reg) begin
            push      = 1'b1;
            push_data = {bus.s_data, low_reg};
          end else begin
            low_next = bus.s_data;
            if (remaining_reg == CNT_W'(1)) begin
              push      = 1'b1;
              push_data = {{DATA_W{1'b0}}, bus.s_data};
            end
          end
          if (remaining_reg == CNT_W'(1)) begin
            state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Leave as the final word is popped so done lands on the next cycle.
        if (fifo_empty || (pop && fifo_level == LVL_W'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  ftdnn_sync_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_l     (clk_l),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (bus.actbuf_wr_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign bus.s_rdy         = rdy;
  assign bus.actbuf_wr_vld = !fifo_empty;
  assign bus.busy          = (state_reg == RUN) || (state_reg == FLUSH);
  assign bus.done          = (state_reg == DONE);

`ifdef FTDNN_ACT_FEEDER_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_reg;
  logic                   start_ok;

  assign start_ok = (state_reg == IDLE) && bus.cfg_start;

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (start_ok) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg != IDLE) && !fifo_empty && !bus.actbuf_wr_req
                 && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt_reg;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ftdnn_act_feeder.sv
// Directed layer runs with random data/handshakes, checked against a pair-packing model.
module tb_ftdnn_act_feeder;
  import ftdnn_act_pkg::*;

  localparam int DW    = ACT_DATA_W;
  localparam int CW    = 16;
  localparam int DEPTH = 8;

  logic clk_l = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_l = ~clk_l;

  ftdnn_act_feeder_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  ftdnn_act_feeder #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk_l (clk_l),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0]   elems[$];
  logic [2*DW-1:0] exp_words[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: element 2k in the low half, 2k+1 (or zero past the end) in the high half.
  task automatic build_exp(input int len);
    logic [DW-1:0] lo, hi;
    exp_words.delete();
    for (int k = 0; 2*k < len; k++) begin
      lo = elems[2*k];
      hi = (2*k + 1 < len) ? elems[2*k+1] : '0;
      exp_words.push_back({hi, lo});
    end
  endtask

  task automatic fill(input int len);
    elems.delete();
    for (int i = 0; i < len; i++) elems.push_back(DW'($urandom));
  endtask

  // mode 0: req high; 1: random req; 2: req low for 30 cycles; 3: 7 stall cycles
  task automatic run_layer(input int len, input int mode, input int abort_after, input int vld_pct);
    int in_idx = 0, out_idx = 0, cyc = 0, last_xfer = -1, stalls = 0;
    bit seen_done = 0;
    build_exp(len);
    @(negedge clk_l);
    bus.cfg_len   = CW'(len);
    bus.cfg_start = 1'b1;
    @(negedge clk_l);
    bus.cfg_start = 1'b0;
    bus.cfg_len   = CW'($urandom);
    chk("busy_after_start", 64'(bus.busy), 64'(len != 0));
    chk("stall_cleared", 64'(bus.stall_cnt), 64'(0));
    while (!seen_done && cyc < 3000) begin
      if (abort_after > 0 && in_idx == abort_after) begin
        bus.s_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_s_rdy", 64'(bus.s_rdy), 64'(0));
        chk("rst_vld", 64'(bus.actbuf_wr_vld), 64'(0));
        chk("rst_data", 64'(bus.actbuf_wr_data), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_stall", 64'(bus.stall_cnt), 64'(0));
        return;
      end
      if (bus.done) begin
        seen_done = 1;
        chk("done_word_count", 64'(out_idx), 64'(exp_words.size()));
        chk("done_latency", 64'(cyc), 64'((len == 0) ? 0 : last_xfer + 1));
        if (len == 0) chk("zero_len_no_vld", 64'(bus.actbuf_wr_vld), 64'(0));
      end else begin
        if (len > 0 && in_idx == len) chk("rdy_after_last", 64'(bus.s_rdy), 64'(0));
        bus.s_vld  = ($urandom_range(99) < vld_pct);
        bus.s_data = (in_idx < len) ? elems[in_idx] : DW'($urandom);
        case (mode)
          0:       bus.actbuf_wr_req = 1'b1;
          1:       bus.actbuf_wr_req = 1'($urandom_range(1));
          2:       bus.actbuf_wr_req = (cyc >= 30);
          default: bus.actbuf_wr_req = !(bus.actbuf_wr_vld && stalls < 7);
        endcase
        if (mode == 2 && cyc == 29) begin
          chk("bp_accepted", 64'(in_idx), 64'(2*DEPTH));
          chk("bp_rdy_low", 64'(bus.s_rdy), 64'(0));
        end
        if (bus.s_vld && bus.s_rdy) in_idx++;
        if (bus.actbuf_wr_vld && !bus.actbuf_wr_req) stalls++;
        if (bus.actbuf_wr_vld && bus.actbuf_wr_req) begin
          if (out_idx < exp_words.size())
            chk($sformatf("word%0d", out_idx), 64'(bus.actbuf_wr_data), 64'(exp_words[out_idx]));
          else
            chk("no_extra_word", 64'(out_idx < exp_words.size()), 64'(1));
          out_idx++;
          last_xfer = cyc;
        end
        @(negedge clk_l);
        cyc++;
      end
    end
    bus.s_vld = 1'b0;
    chk("done_seen", 64'(seen_done), 64'(1));
    @(negedge clk_l);
    chk("done_one_cycle", 64'(bus.done), 64'(0));
    chk("busy_end", 64'(bus.busy), 64'(0));
`ifdef FTDNN_ACT_FEEDER_STALL_CNT_EN
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(stalls));
`else
    chk("stall_cnt_off", 64'(bus.stall_cnt), 64'(0));
`endif
    $display("layer len=%0d mode=%0d: %0d in, %0d words, %0d stall cycles", len, mode, in_idx, out_idx, stalls);
  endtask

  initial begin
    bus.cfg_len       = '0;
    bus.cfg_start     = 1'b0;
    bus.s_data        = '0;
    bus.s_vld         = 1'b0;
    bus.actbuf_wr_req = 1'b0;
    rst_n             = 1'b0;
    repeat (3) @(negedge clk_l);
    chk("reset_s_rdy", 64'(bus.s_rdy), 64'(0));
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_done", 64'(bus.done), 64'(0));
    chk("reset_vld", 64'(bus.actbuf_wr_vld), 64'(0));
    chk("reset_data", 64'(bus.actbuf_wr_data), 64'(0));
    chk("reset_stall", 64'(bus.stall_cnt), 64'(0));
    rst_n = 1'b1;

    elems.delete();
    elems.push_back(DW'(8'h11)); elems.push_back(DW'(8'h22));
    elems.push_back(DW'(8'h33)); elems.push_back(DW'(8'h44));
    run_layer(4, 0, 0, 100);

    elems.delete();
    elems.push_back(DW'(8'hA1)); elems.push_back(DW'(8'hA2)); elems.push_back(DW'(8'hA3));
    run_layer(3, 0, 0, 100);

    fill(40);
    run_layer(40, 2, 0, 100);

    run_layer(0, 0, 0, 100);

    fill(10);
    run_layer(10, 1, 5, 70);
    @(negedge clk_l);
    rst_n = 1'b1;
    fill(2);
    run_layer(2, 0, 0, 100);

    fill(5);
    run_layer(5, 3, 0, 100);
    fill(1);
    run_layer(1, 0, 0, 100);

    for (int r = 0; r < 6; r++) begin
      fill(int'($urandom_range(1, 25)));
      run_layer(elems.size(), 1, 0, 60);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
